joystick_seq_gen: RTL

- Parametrised successor to the joystick pass-sequence checker.
- Sequences the ADC between the Y and X channels on each capture request, then decodes the joystick direction.
- Accumulates SEQ_LEN entries and compares them against the pass sequence.
- Adds discard of centred captures, fail counting with timed lockout, and optional on-chip enrolment. Sits between keypad/ADC glue and the safe-lock output logic.

---
 rtl/joystick_seq_gen.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/joystick_seq_gen.sv
// joystick_seq_gen: capture-driven joystick pass-sequence checker.
// On each capture pulse the ADC is steered to the Y channel, then the X channel,
// and the two high nibbles are decoded into a direction (MID/UP/DOWN/LEFT/RIGHT).
// Non-centred directions are stored; when SEQ_LEN are held they are compared
// against the pass sequence. Consecutive failures lead to a timed lockout.
//
// Optional build macro: JOYSTICK_ENROLL_EN adds the enroll input and an on-chip
// sequence register (reset to PASS_SEQ) that a full entry can overwrite.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   capture          pulse: start a Y/X sample sequence
//   delete           pulse: drop the newest stored entry
//   clear            pulse: abort and clear entry, count, pass, fail
//   enroll           (JOYSTICK_ENROLL_EN only) store entry instead of comparing
//   adc_result       12-bit conversion result for the selected channel
//   chan             ADC channel select
//   entry, count     stored directions (slot k at [4k+3:4k]) and how many
//   busy             not IDLE
//   pass, fail       sequence result flags
//   locked           lockout active
//
// state  | meaning
// IDLE   | waiting for capture/delete/clear
// SET_Y  | ADC on Y channel, settling
// READ_Y | latch Y nibble
// SET_X  | ADC on X channel, settling
// READ_X | latch X nibble
// EVAL   | decode, store non-centred direction
// CHECK  | compare full entry against the pass sequence
// LOCK   | lockout timer running, inputs ignored
module joystick_seq_gen #(
    parameter int                   SEQ_LEN    = 4,
    parameter int                   SETTLE_CYC = 50,
    parameter int                   MAX_FAILS  = 3,
    parameter int                   LOCK_CYC   = 50_000_000,
    parameter logic [4*SEQ_LEN-1:0] PASS_SEQ   = 16'h3221,
    parameter logic [2:0]           Y_CHAN     = 3'd1,
    parameter logic [2:0]           X_CHAN     = 3'd0,
    localparam int                  CW         = $clog2(SEQ_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   delete,
    input  logic                   clear,
`ifdef JOYSTICK_ENROLL_EN
    input  logic                   enroll,
`endif
    input  logic [11:0]            adc_result,
    output logic [2:0]             chan,
    output logic [4*SEQ_LEN-1:0]   entry,
    output logic [CW-1:0]          count,
    output logic                   busy,
    output logic                   pass,
    output logic                   fail,
    output logic                   locked
);

    localparam int SW = $clog2(SETTLE_CYC);
    localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [3:0] DIR_MID   = 4'd0;
    localparam logic [3:0] DIR_UP    = 4'd1;
    localparam logic [3:0] DIR_DOWN  = 4'd2;
    localparam logic [3:0] DIR_LEFT  = 4'd3;
    localparam logic [3:0] DIR_RIGHT = 4'd4;

    typedef enum logic [2:0] {
        IDLE, SET_Y, READ_Y, SET_X, READ_X, EVAL, CHECK, LOCK
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [LW-1:0]        lock_q, lock_d;
    logic [3:0]           ny_q, ny_d, nx_q, nx_d;
    logic [4*SEQ_LEN-1:0] entry_q, entry_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 pass_q, pass_d, fail_q, fail_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [FW-1:0]        fcnt_inc;
    logic [3:0]           dir;
    logic                 enroll_now;
    logic [4*SEQ_LEN-1:0] ref_seq;
    logic [7:0]           adc_lsb_unused;

    assign adc_lsb_unused = adc_result[7:0];

`ifdef JOYSTICK_ENROLL_EN
    logic [4*SEQ_LEN-1:0] seq_q, seq_d;
    assign ref_seq    = seq_q;
    assign enroll_now = enroll;
`else
    assign ref_seq    = PASS_SEQ;
    assign enroll_now = 1'b0;
`endif

    function automatic logic is_ext(input logic [3:0] n);
        return (n == 4'h0) || (n == 4'hC);
    endfunction

    always_comb begin
        dir = DIR_MID;
        if      (ny_q == 4'h0 && !is_ext(nx_q)) dir = DIR_UP;
        else if (ny_q == 4'hC && !is_ext(nx_q)) dir = DIR_DOWN;
        else if (nx_q == 4'h0 && !is_ext(ny_q)) dir = DIR_LEFT;
        else if (nx_q == 4'hC && !is_ext(ny_q)) dir = DIR_RIGHT;
    end

    assign fcnt_inc = fcnt_q + FW'(1);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        lock_d   = lock_q;
        ny_d     = ny_q;
        nx_d     = nx_q;
        entry_d  = entry_q;
        count_d  = count_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        fcnt_d   = fcnt_q;
`ifdef JOYSTICK_ENROLL_EN
        seq_d    = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d  = SET_Y;
                    settle_d = SW'(SETTLE_CYC - 1);
                    fail_d   = 1'b0;
                end else if (delete && count_q != '0) begin
                    for (int k = 0; k < SEQ_LEN; k++)
                        if (CW'(k + 1) == count_q) entry_d[4*k +: 4] = 4'h0;
                    count_d = count_q - CW'(1);
                end
            end
            SET_Y: begin
                if (settle_q == '0) state_d = READ_Y;
                else                settle_d = settle_q - SW'(1);
            end
            READ_Y: begin
                ny_d     = adc_result[11:8];
                state_d  = SET_X;
                settle_d = SW'(SETTLE_CYC - 1);
            end
            SET_X: begin
                if (settle_q == '0) state_d = READ_X;
                else                settle_d = settle_q - SW'(1);
            end
            READ_X: begin
                nx_d    = adc_result[11:8];
                state_d = EVAL;
            end
            EVAL: begin
                state_d = IDLE;
                if (dir != DIR_MID) begin
                    for (int k = 0; k < SEQ_LEN; k++)
                        if (CW'(k) == count_q) entry_d[4*k +: 4] = dir;
                    count_d = count_q + CW'(1);
                    if (count_q + CW'(1) == CW'(SEQ_LEN)) state_d = CHECK;
                end
            end
            CHECK: begin
                entry_d = '0;
                count_d = '0;
                state_d = IDLE;
                if (enroll_now) begin
`ifdef JOYSTICK_ENROLL_EN
                    seq_d = entry_q;
`endif
                end else if (entry_q == ref_seq) begin
                    pass_d = 1'b1;
                    fcnt_d = '0;
                end else begin
                    fail_d = 1'b1;
                    fcnt_d = fcnt_inc;
                    if (fcnt_inc >= FW'(MAX_FAILS)) begin
                        state_d = LOCK;
                        lock_d  = LW'(LOCK_CYC - 1);
                    end
                end
            end
            LOCK: begin
                if (lock_q == '0) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    lock_d = lock_q - LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // clear overrides everything except the lockout; fail history is kept
        if (clear && state_q != LOCK) begin
            state_d = IDLE;
            entry_d = '0;
            count_d = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
            lock_q   <= '0;
            ny_q     <= '0;
            nx_q     <= '0;
            entry_q  <= '0;
            count_q  <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            fcnt_q   <= '0;
`ifdef JOYSTICK_ENROLL_EN
            seq_q    <= PASS_SEQ;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            lock_q   <= lock_d;
            ny_q     <= ny_d;
            nx_q     <= nx_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            fcnt_q   <= fcnt_d;
`ifdef JOYSTICK_ENROLL_EN
            seq_q    <= seq_d;
`endif
        end
    end

    // channel follows the state so the ADC stays on Y through the read cycle
    assign chan   = (state_q == SET_Y || state_q == READ_Y) ? Y_CHAN : X_CHAN;
    assign entry  = entry_q;
    assign count  = count_q;
    assign busy   = (state_q != IDLE);
    assign pass   = pass_q;
    assign fail   = fail_q;
    assign locked = (state_q == LOCK);

endmodule
